// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: fixed-latency instruction memory answering PC fetches; `FETCH_ERR_EN adds rsp_err
module instr_fetch_responder #(
    parameter int INSTR_ADDR_WIDTH = 20,
    parameter int INSTR_WIDTH      = 32,
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int STEP             = 2,
    parameter int WAIT_STATES      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [INSTR_ADDR_WIDTH-1:0] req_addr,
    output logic                        req_ready,
    input  logic                        flush,
    output logic                        rsp_valid,
    output logic [INSTR_WIDTH-1:0]      rsp_instr,
`ifdef FETCH_ERR_EN
    output logic                        rsp_err,
`endif
    input  logic                        rsp_ready,
    input  logic                        ld_we,
    input  logic [MEM_DEPTH_LOG2-1:0]   ld_addr,
    input  logic [INSTR_WIDTH-1:0]      ld_data
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic [MEM_DEPTH_LOG2-1:0] idx, addr_idx, rd_idx;
    logic [INSTR_WIDTH-1:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];
    logic accept, enter_resp, rd_err;
    assign req_ready  = (state == S_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign addr_idx   = req_addr[MEM_DEPTH_LOG2+STEP-1:STEP];
    assign enter_resp = (state_n == S_RESP) && (state != S_RESP);
    // With zero wait states the array is read on the accept edge itself, straight from the request
    assign rd_idx     = (state == S_IDLE) ? addr_idx : idx;
`ifdef FETCH_ERR_EN
    localparam logic [INSTR_ADDR_WIDTH-1:0] LO_MASK = INSTR_ADDR_WIDTH'((1 << STEP) - 1);
    logic err_q, addr_err;
    assign addr_err = ((req_addr & LO_MASK) != '0) || ((req_addr >> (MEM_DEPTH_LOG2 + STEP)) != '0);
    assign rd_err   = (state == S_IDLE) ? addr_err : err_q;
    // Error flag is latched with the request and presented alongside rsp_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            if (accept) err_q <= addr_err;
            if (enter_resp) rsp_err <= rd_err;
            else if (state_n == S_IDLE) rsp_err <= 1'b0;
        end
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;
    assign rd_err = 1'b0;
`endif
    // Next-state: flush outranks both the wait countdown and rsp_ready
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = accept ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE;
            S_WAIT:  state_n = flush ? S_IDLE : (cnt == 4'd1 ? S_RESP : S_WAIT);
            S_RESP:  state_n = (flush || rsp_ready) ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end
    // Loader writes land in any state; a same-edge read still sees the old word
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end
    // State, wait counter, request latch and the registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                idx <= addr_idx;
                cnt <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_instr <= rd_err ? '0 : mem[rd_idx];
            end else if (state_n == S_IDLE) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb_instr_fetch_responder: three responders (0/1/3 wait states) on shared stimulus vs a timestamp model
module tb_instr_fetch_responder;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b1, ld_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [9:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic rq [3], rv [3];
    logic [31:0] ri [3];
`ifdef FETCH_ERR_EN
    logic re [3];
    logic derr [3];
`endif
    int ws [3] = '{0, 1, 3};
    int checks = 0, failures = 0, cyc = 0;
    logic started = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_fetch_responder #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
            .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rq[g]),
            .flush(flush), .rsp_valid(rv[g]), .rsp_instr(ri[g]),
`ifdef FETCH_ERR_EN
            .rsp_err(re[g]),
`endif
            .rsp_ready(rsp_ready), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [19:0] a);
`ifdef FETCH_ERR_EN
        return (a[1:0] != 2'b0) || (a[19:12] != 8'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] pat(input int i);
        return (i * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    // Model: a fetch accepted at edge c yields its word at edge c+WS, read from the array before that edge's write
    logic [31:0] mm [1024];
    logic m_busy [3], m_have [3], m_err [3];
    int m_due [3];
    logic [9:0] m_idx [3];
    logic [31:0] m_word [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 1'b0;
                m_have[k] = 1'b0;
                m_err[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_busy[k]) begin
                    if (req_valid && !flush) begin
                        m_busy[k] = 1'b1;
                        m_idx[k]  = req_addr[11:2];
                        m_err[k]  = addr_bad(req_addr);
                        m_due[k]  = cyc + ws[k];
                    end
                end else if (flush || (m_have[k] && rsp_ready)) begin
                    m_busy[k] = 1'b0;
                    m_have[k] = 1'b0;
                end
                if (m_busy[k] && !m_have[k] && cyc == m_due[k]) begin
                    m_have[k] = 1'b1;
                    m_word[k] = m_err[k] ? 32'h0 : mm[m_idx[k]];
                end
            end
            if (ld_we) mm[ld_addr] = ld_data;
        end
        cyc++;
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (started && !rst) begin
            for (int k = 0; k < 3; k++) begin
                chk("req_ready", k, {31'b0, rq[k]}, {31'b0, !m_busy[k] && !flush});
                chk("rsp_valid", k, {31'b0, rv[k]}, {31'b0, m_have[k]});
                if (m_have[k]) chk("rsp_instr", k, ri[k], m_word[k]);
`ifdef FETCH_ERR_EN
                if (m_have[k]) chk("rsp_err", k, {31'b0, re[k]}, {31'b0, m_err[k]});
`endif
            end
        end
    end

    int lat [3];
    logic [31:0] dat [3];

    task automatic load(input int i, input logic [31:0] d);
        @(posedge clk); #1;
        ld_we = 1'b1; ld_addr = 10'(i); ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [19:0] a, input logic we, input logic [9:0] la, input logic [31:0] ld);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; ld_we = we; ld_addr = la; ld_data = ld;
        @(posedge clk); #1;
        req_valid = 1'b0; ld_we = 1'b0;
        for (int k = 0; k < 3; k++) lat[k] = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (rv[k] === 1'b1 && lat[k] == 0) begin
                lat[k] = n;
                dat[k] = ri[k];
`ifdef FETCH_ERR_EN
                derr[k] = re[k];
`endif
            end
        end
    endtask

    task automatic check_fetch(input string nm, input logic [31:0] w0, input logic [31:0] w12, input logic e);
        for (int k = 0; k < 3; k++) begin
            chk({nm, "_lat"}, k, lat[k], 1 + ws[k]);
            chk({nm, "_data"}, k, dat[k], e ? 32'h0 : (k == 0 ? w0 : w12));
`ifdef FETCH_ERR_EN
            chk({nm, "_err"}, k, {31'b0, derr[k]}, {31'b0, e});
`endif
        end
    endtask

    initial begin
        int cnt2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, {31'b0, rq[k]}, 32'd1);
            chk("rst_valid", k, {31'b0, rv[k]}, 32'd0);
            chk("rst_instr", k, ri[k], 32'd0);
        end
        for (int i = 0; i < 1024; i++)
            load(i, i == 0 ? 32'h0000_0013 : i == 1 ? 32'h0010_0093 : i == 1023 ? 32'hDEAD_BEEF : pat(i));
        do_fetch(20'h00000, 1'b0, 10'd0, 32'h0);
        check_fetch("fetch0", 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_fetch(20'h00004, 1'b0, 10'd0, 32'h0);
        check_fetch("fetch4", 32'h0010_0093, 32'h0010_0093, 1'b0);
        // Back-pressure: response must hold and no new request may be accepted
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 20'h00004;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("bp_valid", k, {31'b0, rv[k]}, 32'd1);
                chk("bp_instr", k, ri[k], 32'h0010_0093);
                chk("bp_ready", k, {31'b0, rq[k]}, 32'd0);
            end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("bp_rel_ready", k, {31'b0, rq[k]}, 32'd1);
            chk("bp_rel_valid", k, {31'b0, rv[k]}, 32'd0);
        end
        // Flush on the second wait cycle of the 3-wait-state responder
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 20'h00008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        cnt2 = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rv[2] === 1'b1) cnt2++;
        end
        chk("flush_no_rsp", 2, cnt2, 0);
        do_fetch(20'h00008, 1'b0, 10'd0, 32'h0);
        check_fetch("after_flush", pat(2), pat(2), 1'b0);
        do_fetch(20'h01004, 1'b0, 10'd0, 32'h0);
        check_fetch("wrap_1004", 32'h0010_0093, 32'h0010_0093, addr_bad(20'h01004));
        do_fetch(20'hFFFFC, 1'b0, 10'd0, 32'h0);
        check_fetch("wrap_fffc", 32'hDEAD_BEEF, 32'hDEAD_BEEF, addr_bad(20'hFFFFC));
        // Loader write to the fetched index on the accept edge: zero-wait responder returns the old word
        do_fetch(20'h00014, 1'b1, 10'd5, 32'hCAFE_F00D);
        check_fetch("collide", pat(5), 32'hCAFE_F00D, 1'b0);
        do_fetch(20'h00014, 1'b0, 10'd0, 32'h0);
        check_fetch("refetch", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
`ifdef FETCH_ERR_EN
        do_fetch(20'h00002, 1'b0, 10'd0, 32'h0);
        check_fetch("err_low", 32'h0, 32'h0, 1'b1);
        do_fetch(20'h10000, 1'b0, 10'd0, 32'h0);
        check_fetch("err_high", 32'h0, 32'h0, 1'b1);
        do_fetch(20'h00008, 1'b0, 10'd0, 32'h0);
        check_fetch("err_none", pat(2), pat(2), 1'b0);
`endif
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = (i == 1500 || i == 1501);
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = ($urandom_range(0, 3) == 0) ? 20'($urandom) : {8'h0, 8'($urandom_range(0, 15)), 2'b00};
            flush     = ($urandom_range(0, 7) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_we     = ($urandom_range(0, 3) == 0);
            ld_addr   = 10'($urandom_range(0, 15));
            ld_data   = $urandom;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0; ld_we = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface driven by the program counter control unit.
- Accepts one fetch address per handshake and returns the instruction word after a fixed, configurable number of wait states.
- Its request-accept / response-fire signals drive the PC unit's enable.
- Holds its own instruction array, written through a simple loader port before or between runs.

Parameters:
- INSTR_ADDR_WIDTH, 20, fetch address width; matches the PC width.
- INSTR_WIDTH, 32, instruction word width.
- MEM_DEPTH_LOG2, 10, log2 of the word count of the internal array.
- STEP, 2, address-to-word shift: word index = req_addr >> STEP. Matches the PC increment step.
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_addr  in  INSTR_ADDR_WIDTH  fetch address (the pc value).
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  redirect (pc_src taken); cancels any in-flight fetch.
- rsp_valid  out  1  rsp_instr is valid.
- rsp_instr  out  INSTR_WIDTH  fetched instruction.
- rsp_ready  in  1  consumer takes the response.
- ld_we  in  1  loader write enable.
- ld_addr  in  MEM_DEPTH_LOG2  loader word index.
- ld_data  in  INSTR_WIDTH  loader write data.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state <= IDLE, rsp_valid <= 0, rsp_instr <= 0, wait counter <= 0.
  - Array contents are not reset. rst has priority over every other input.
- req_ready = (state==IDLE) && !flush. It is combinational and reads 1 in the first cycle after reset.
- Accept: req_valid && req_ready at an edge.
  - Latch word index = req_addr[MEM_DEPTH_LOG2+STEP-1:STEP].
  - Load the counter with WAIT_STATES.
- States:
  - IDLE: on accept -> WAIT if WAIT_STATES>0, else -> RESP.
  - WAIT: counter decrements each cycle. When the counter is 1 at an edge -> RESP.
  - Entry into RESP: rsp_instr <= mem[latched index]; rsp_valid <= 1.
  - RESP: hold rsp_valid and rsp_instr stable until rsp_ready=1 at an edge, then -> IDLE with rsp_valid <= 0.
- Latency: accept to rsp_valid high = 1+WAIT_STATES cycles.
- Throughput: one fetch per (2+WAIT_STATES) cycles; no request is accepted while a response is pending.
- Flush:
  - In WAIT or RESP: next state is IDLE and rsp_valid <= 0; the in-flight response is discarded and never delivered.
  - flush has priority over rsp_ready in the same cycle.
  - In IDLE with req_valid: no accept.
- Address rules:
  - Low STEP bits of req_addr are ignored.
  - Bits above MEM_DEPTH_LOG2+STEP are ignored; the address wraps onto the array.
  - req_addr all-ones is a legal fetch of the last word.
- Loader:
  - ld_we writes mem[ld_addr] at the edge, in any state.
  - If the write targets the latched index on the edge that enters RESP, rsp_instr gets the OLD word; the write still lands.
- With rsp_ready tied to 1, each fetch fires exactly once, and the PC enable = rsp_valid && rsp_ready.

Optional Feature:
- Macro FETCH_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit), reset 0, valid with rsp_valid.
  - rsp_err=1 when the latched address had nonzero low STEP bits, or nonzero bits above MEM_DEPTH_LOG2+STEP.
  - In that case rsp_instr = 0 and the array is not read.
  - rsp_err clears with rsp_valid.
- Not defined: no rsp_err port; the wrap and ignore rules above apply.

Test Plan:
- Reset then basic fetch:
  - Load mem[0]=0x00000013, mem[1]=0x00100093. WAIT_STATES=1, rsp_ready=1.
  - Request addr 0x00000 -> rsp_valid 2 cycles after accept with 0x00000013.
  - Request addr 0x00004 -> 0x00100093.
- Back-pressure:
  - rsp_ready=0 for 5 cycles after rsp_valid -> rsp_instr holds the same value and req_ready=0 throughout.
  - Raise rsp_ready -> IDLE next cycle, req_ready=1.
- Flush mid-wait: WAIT_STATES=3, flush on the 2nd wait cycle -> rsp_valid never asserts; the next request completes normally.
- Wrap: MEM_DEPTH_LOG2=10, addr 0x01004 -> returns mem[1]; addr 0xFFFFC -> returns mem[1023].
- Zero wait states and loader collision:
  - WAIT_STATES=0 -> rsp_valid exactly 1 cycle after accept.
  - ld_we to the same index on the accept edge -> old word returned; a re-fetch returns the new word.
- FETCH_ERR_EN:
  - addr 0x00002 -> rsp_err=1, rsp_instr=0.
  - addr 0x10000 -> rsp_err=1.
  - addr 0x00008 -> rsp_err=0 with mem[2].
